// File: rtl/jac_to_affine.sv
// Jacobian-to-affine conversion for secp256k1: x = X/Z^2, y = Y/Z^3 mod P.
// Z^-1 comes from an external mod_inv; the four products use a bit-serial interleaved multiplier.
module jac_to_affine #(
  parameter int             W = 256,
  parameter logic [W-1:0]   P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  output logic         inv_start,
  output logic [W-1:0] inv_a,
  input  logic [W-1:0] inv_result,
  input  logic         inv_done,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic         inf,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE, INV_REQ, INV_WAIT, MUL_Z2, MUL_Z3, MUL_X, MUL_Y, DONE
  } state_t;

  localparam int            CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  x_r, y_r, zi_r, z2_r, z3_r;
  logic [W-1:0]  acc_r, mul_a_r, mul_b_r;
  logic [W-1:0]  step_s, a_sel_s, b_sel_s;

  // One multiplier step: double-and-reduce, then conditional add-and-reduce.
  // Both intermediates stay below 2P, so a single subtract of P fully reduces.
  function automatic logic [W-1:0] mod_step(input logic [W-1:0] acc,
                                            input logic [W-1:0] a,
                                            input logic         bit_b);
    logic [W:0]   dbl;
    logic [W:0]   sum;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    dbl = {acc, 1'b0};
    if (dbl >= {1'b0, P}) begin
      r1 = W'(dbl - {1'b0, P});
    end else begin
      r1 = dbl[W-1:0];
    end
    sum = {1'b0, r1} + (bit_b ? {1'b0, a} : {(W+1){1'b0}});
    if (sum >= {1'b0, P}) begin
      r2 = W'(sum - {1'b0, P});
    end else begin
      r2 = sum[W-1:0];
    end
    return r2;
  endfunction

  // Next accumulator value for the current step (multiplier MSB drives the add).
  always_comb begin
    step_s = mod_step(acc_r, mul_a_r, mul_b_r[W-1]);
  end

  // Operand pair loaded at the start of each multiply phase.
  always_comb begin
    a_sel_s = {W{1'b0}};
    b_sel_s = {W{1'b0}};
    case (state_r)
      MUL_Z2: begin a_sel_s = zi_r; b_sel_s = zi_r; end
      MUL_Z3: begin a_sel_s = z2_r; b_sel_s = zi_r; end
      MUL_X:  begin a_sel_s = x_r;  b_sel_s = z2_r; end
      MUL_Y:  begin a_sel_s = y_r;  b_sel_s = z3_r; end
      default: begin a_sel_s = {W{1'b0}}; b_sel_s = {W{1'b0}}; end
    endcase
  end

  // Control FSM, operand storage, multiplier datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      x_r       <= {W{1'b0}};
      y_r       <= {W{1'b0}};
      zi_r      <= {W{1'b0}};
      z2_r      <= {W{1'b0}};
      z3_r      <= {W{1'b0}};
      acc_r     <= {W{1'b0}};
      mul_a_r   <= {W{1'b0}};
      mul_b_r   <= {W{1'b0}};
      inv_start <= 1'b0;
      inv_a     <= {W{1'b0}};
      x_out     <= {W{1'b0}};
      y_out     <= {W{1'b0}};
      inf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            x_r  <= x_in;
            y_r  <= y_in;
            busy <= 1'b1;
            if (z_in == {W{1'b0}}) begin
              x_out   <= {W{1'b0}};
              y_out   <= {W{1'b0}};
              inf     <= 1'b1;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              inv_a     <= z_in;
              inv_start <= 1'b1;
              state_r   <= INV_REQ;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        INV_REQ: begin
          inv_start <= 1'b0;
          state_r   <= INV_WAIT;
        end
        INV_WAIT: begin
          if (inv_done) begin
            zi_r    <= inv_result;
            cnt_r   <= {CW{1'b0}};
            state_r <= MUL_Z2;
          end else begin
            state_r <= INV_WAIT;
          end
        end
        MUL_Z2, MUL_Z3, MUL_X, MUL_Y: begin
          if (cnt_r == {CW{1'b0}}) begin
            acc_r   <= {W{1'b0}};
            mul_a_r <= a_sel_s;
            mul_b_r <= b_sel_s;
            cnt_r   <= CW'(1);
          end else begin
            acc_r   <= step_s;
            mul_b_r <= mul_b_r << 1;
            if (cnt_r == LAST) begin
              cnt_r <= {CW{1'b0}};
              case (state_r)
                MUL_Z2: begin z2_r <= step_s; state_r <= MUL_Z3; end
                MUL_Z3: begin z3_r <= step_s; state_r <= MUL_X;  end
                // X is no longer needed once loaded, so its slot holds affine x.
                MUL_X:  begin x_r  <= step_s; state_r <= MUL_Y;  end
                MUL_Y: begin
                  x_out   <= x_r;
                  y_out   <= step_s;
                  inf     <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
                end
                default: state_r <= IDLE;
              endcase
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jac_to_affine.sv
// Self-checking bench for jac_to_affine: a behavioural mod_inv stub plus a
// big-integer reference model (plain % arithmetic) for the affine result.
module tb_jac_to_affine;

  localparam logic [255:0] P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam int LAT = 1029;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] x_in = '0, y_in = '0, z_in = '0;
  logic         inv_start;
  logic [255:0] inv_a;
  logic [255:0] inv_result;
  logic         inv_done;
  logic [255:0] x_out, y_out;
  logic         inf, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  jac_to_affine dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .inv_start(inv_start), .inv_a(inv_a),
    .inv_result(inv_result), .inv_done(inv_done),
    .x_out(x_out), .y_out(y_out), .inf(inf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, P};
    return t[255:0];
  endfunction

  // Fermat inverse: z^(P-2) mod P.
  function automatic logic [255:0] invmod(input logic [255:0] z);
    logic [255:0] r, base, e;
    r = 256'd1;
    base = z;
    e = P - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, base);
      base = mulmod(base, base);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
    if (v >= P) v = v - P;
    return v;
  endfunction

  // mod_inv stub: clears done when it samples start, asserts done+result after stub_lat cycles.
  int           stub_lat = 3;
  int           stub_cnt;
  logic         stub_busy;
  logic [255:0] stub_op;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_done   <= 1'b0;
      inv_result <= '0;
      stub_busy  <= 1'b0;
      stub_cnt   <= 0;
      stub_op    <= '0;
    end else if (inv_start) begin
      inv_done  <= 1'b0;
      stub_busy <= 1'b1;
      stub_cnt  <= stub_lat;
      stub_op   <= inv_a;
    end else if (stub_busy) begin
      if (stub_cnt <= 1) begin
        inv_done   <= 1'b1;
        inv_result <= invmod(stub_op);
        stub_busy  <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Cycle counter and event monitor, sampled mid-cycle.
  int           cyc = 0;
  int           done_cnt = 0, inv_start_cnt = 0;
  int           done_cyc = 0, inv_start_cyc = 0, invd_cyc = 0;
  bit           invd_seen = 1'b0;
  logic [255:0] cap_x, cap_y, cap_inva;
  logic         cap_inf, cap_busy;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (inv_start) begin
      inv_start_cnt <= inv_start_cnt + 1;
      inv_start_cyc <= cyc;
      cap_inva      <= inv_a;
      invd_seen     <= 1'b0;
    end else if (inv_done && !invd_seen) begin
      invd_seen <= 1'b1;
      invd_cyc  <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      cap_x    <= x_out;
      cap_y    <= y_out;
      cap_inf  <= inf;
      cap_busy <= busy;
    end
  end

  task automatic issue(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                       output int scyc);
    @(negedge clk);
    x_in = x; y_in = y; z_in = z;
    start = 1'b1;
    scyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < 1300) begin
      @(negedge clk); #1;
      if (done_cnt > base) ok = 1'b1;
      i++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if ({inv_start, done, busy, inf} !== 4'b0000) begin n_err++;
      $display("FAIL reset_ctl: got %b want 0000", {inv_start, done, busy, inf}); end
    n_cmp++; if (x_out !== 256'd0 || y_out !== 256'd0 || inv_a !== 256'd0) begin n_err++;
      $display("FAIL reset_data: x=%h y=%h inv_a=%h want 0", x_out, y_out, inv_a); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_z1(input logic [255:0] x, input logic [255:0] y, input string tag);
    int s, b0, i0; bit ok;
    stub_lat = 3;
    b0 = done_cnt; i0 = inv_start_cnt;
    issue(x, y, 256'd1, s);
    wait_done(b0, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_timeout: no done within bound", tag); end
    n_cmp++; if (inv_start_cyc !== s + 1) begin n_err++;
      $display("FAIL %s_inv_start_lat: got cycle %0d want %0d", tag, inv_start_cyc, s + 1); end
    n_cmp++; if (inv_start_cnt - i0 !== 1) begin n_err++;
      $display("FAIL %s_inv_start_cnt: got %0d want 1", tag, inv_start_cnt - i0); end
    n_cmp++; if (done_cyc !== invd_cyc + LAT) begin n_err++;
      $display("FAIL %s_latency: got %0d want %0d", tag, done_cyc - invd_cyc, LAT); end
    n_cmp++; if (cap_x !== x || cap_y !== y || cap_inf !== 1'b0 || cap_busy !== 1'b1) begin n_err++;
      $display("FAIL %s_result: got x=%h y=%h inf=%b busy=%b want x=%h y=%h inf=0 busy=1",
               tag, cap_x, cap_y, cap_inf, cap_busy, x, y); end
    @(negedge clk); #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || x_out !== x) begin n_err++;
      $display("FAIL %s_after_done: done=%b busy=%b x=%h want 0 0 held", tag, done, busy, x_out); end
  endtask

  task automatic test_z0();
    int s, b0, i0; bit ok;
    b0 = done_cnt; i0 = inv_start_cnt;
    issue(rand_fe(), rand_fe(), 256'd0, s);
    wait_done(b0, ok);
    n_cmp++; if (!ok || done_cyc !== s + 1) begin n_err++;
      $display("FAIL z0_latency: done cycle %0d want %0d", done_cyc, s + 1); end
    n_cmp++; if (inv_start_cnt !== i0) begin n_err++;
      $display("FAIL z0_no_inv: got %0d inv_start pulses want 0", inv_start_cnt - i0); end
    n_cmp++; if (cap_inf !== 1'b1 || cap_x !== 256'd0 || cap_y !== 256'd0) begin n_err++;
      $display("FAIL z0_result: inf=%b x=%h y=%h want 1 0 0", cap_inf, cap_x, cap_y); end
  endtask

  task automatic run_model(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                           input logic [255:0] ex, input logic [255:0] ey, input string tag);
    int s, b0; bit ok;
    stub_lat = $urandom_range(1, 10);
    b0 = done_cnt;
    issue(x, y, z, s);
    wait_done(b0, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_timeout: no done within bound", tag); end
    n_cmp++; if (cap_inva !== z) begin n_err++;
      $display("FAIL %s_inv_a: got %h want %h", tag, cap_inva, z); end
    n_cmp++; if (cap_x !== ex || cap_y !== ey || cap_inf !== 1'b0) begin n_err++;
      $display("FAIL %s_result: got x=%h y=%h inf=%b want x=%h y=%h", tag, cap_x, cap_y, cap_inf, ex, ey); end
    n_cmp++; if (done_cyc !== invd_cyc + LAT) begin n_err++;
      $display("FAIL %s_latency: got %0d want %0d", tag, done_cyc - invd_cyc, LAT); end
  endtask

  task automatic test_random();
    logic [255:0] x, y, z, zi;
    for (int k = 0; k < 4; k++) begin
      x = rand_fe(); y = rand_fe(); z = rand_fe();
      if (z == 256'd0) z = 256'd3;
      zi = invmod(z);
      run_model(x, y, z, mulmod(x, mulmod(zi, zi)), mulmod(y, mulmod(mulmod(zi, zi), zi)),
                $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_ignore_start();
    int s, d, b0, i0; bit ok;
    logic [255:0] x, y, z, zi;
    x = rand_fe(); y = rand_fe(); z = 256'd7;
    zi = invmod(z);
    stub_lat = 3;
    b0 = done_cnt; i0 = inv_start_cnt;
    issue(x, y, z, s);
    repeat (2) @(negedge clk);
    issue(rand_fe(), rand_fe(), 256'd0, d);      // lands in INV_WAIT
    repeat (600) @(negedge clk);
    issue(rand_fe(), rand_fe(), 256'd5, d);      // lands in MUL_X
    wait_done(b0, ok);
    n_cmp++; if (!ok || cap_x !== mulmod(x, mulmod(zi, zi)) || cap_y !== mulmod(y, mulmod(mulmod(zi, zi), zi))
                 || cap_inf !== 1'b0) begin n_err++;
      $display("FAIL ignore_result: got x=%h y=%h inf=%b", cap_x, cap_y, cap_inf); end
    repeat (1100) @(negedge clk);
    #1;
    n_cmp++; if (done_cnt - b0 !== 1 || inv_start_cnt - i0 !== 1) begin n_err++;
      $display("FAIL ignore_pulses: done=%0d inv_start=%0d want 1 1", done_cnt - b0, inv_start_cnt - i0); end
  endtask

  task automatic test_reset_mid();
    int s;
    issue(rand_fe(), rand_fe(), 256'd3, s);
    repeat (4 + 257 + 100) @(negedge clk);     // inside MUL_Z3
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (x_out !== 256'd0 || y_out !== 256'd0 || {busy, done, inf, inv_start} !== 4'b0000) begin n_err++;
      $display("FAIL midrst_outputs: x=%h y=%h ctl=%b want 0", x_out, y_out, {busy, done, inf, inv_start}); end
    @(negedge clk); rst = 1'b0;
    test_z1(256'd9, 256'd3, "after_rst");
  endtask

  initial begin
    logic [255:0] zi2;
    test_reset();
    test_z1(256'd5, 256'd7, "z1");
    test_z0();
    run_model(256'd4, 256'd8, 256'd2, 256'd1, 256'd1, "z2");
    run_model(mulmod(256'd4, GX), mulmod(256'd8, GY), 256'd2, GX, GY, "gen");
    zi2 = (P + 256'd1) >> 1;
    n_cmp++; if (invmod(256'd2) !== zi2) begin n_err++;
      $display("FAIL model_inv2: got %h want %h", invmod(256'd2), zi2); end
    test_random();
    test_ignore_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
